// File: rtl/frame_pkg.sv
// Shared frame definitions for the transmit path and its aligner counterpart.
// Holds the frame state encoding, the header byte constants and the
// default payload length, plus a helper that selects a header byte.
package frame_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HLSB = 2'd1,
    TX_HMSB = 2'd2,
    TX_DATA = 2'd3
  } tx_state_e;

  localparam logic [7:0] HDR_A_LSB = 8'hAA;
  localparam logic [7:0] HDR_A_MSB = 8'hAF;
  localparam logic [7:0] HDR_B_LSB = 8'h55;
  localparam logic [7:0] HDR_B_MSB = 8'hBA;

  localparam int FRAME_PAYLOAD_LEN = 10;

  // Header byte for type A (sel=0) or B (sel=1); msb picks the second byte.
  function automatic logic [7:0] hdr_byte(input logic sel, input logic msb);
    logic [7:0] b;
    case ({sel, msb})
      2'b00:   b = HDR_A_LSB;
      2'b01:   b = HDR_A_MSB;
      2'b10:   b = HDR_B_LSB;
      default: b = HDR_B_MSB;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/frame_tx_fifo.sv
// Synchronous byte FIFO buffering payload ahead of the frame generator.
// Ports:
//   clk, reset    clock, asynchronous active-high reset (empties the FIFO)
//   push_i/wdata_i write strobe and data; ignored while full
//   pop_i/rdata_o  read strobe; rdata_o shows the head entry combinationally
//   count_o        registered occupancy, 0..DEPTH
//   full_o/empty_o derived from the registered count
module frame_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/frame_generator.sv
// Transmit framer: buffers payload bytes and emits one byte per clock as
// [hdr LSB][hdr MSB][PAYLOAD_LEN payload bytes], IDLE_BYTE between frames.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   enable             frames may start; clearing it lets the current frame end
//   hdr_sel            0 = type A header, 1 = type B (sampled at frame start)
//   corrupt_hdr        invert the MSB header byte (sampled at frame start)
//   s_data/s_valid/s_ready  upstream payload handshake
//   tx_data            registered byte stream
//   tx_sof             high while tx_data carries the LSB header byte
//   tx_byte_pos        0/1 header, 2..PAYLOAD_LEN+1 payload, 0 when idle
//   frames_sent        completed frame counter, wraps
module frame_generator
  import frame_pkg::*;
#(
  parameter int         PAYLOAD_LEN = FRAME_PAYLOAD_LEN,
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        hdr_sel,
  input  logic        corrupt_hdr,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  tx_data,
  output logic        tx_sof,
  output logic [3:0]  tx_byte_pos,
  output logic [15:0] frames_sent
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  // An idle byte that looks like a header LSB would fake frame starts downstream.
  if (IDLE_BYTE == HDR_A_LSB || IDLE_BYTE == HDR_B_LSB) begin : g_bad_idle
    $error("frame_generator: IDLE_BYTE must not equal a header LSB byte");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 || FIFO_DEPTH < PAYLOAD_LEN) begin : g_bad_depth
    $error("frame_generator: FIFO_DEPTH must be a power of two >= PAYLOAD_LEN");
  end
  if (PAYLOAD_LEN < 1 || PAYLOAD_LEN > 14) begin : g_bad_len
    $error("frame_generator: PAYLOAD_LEN must fit the 4-bit byte position");
  end

  tx_state_e     state_q, state_d;
  logic          hsel_q, hsel_d, corr_q, corr_d;
  logic [3:0]    pay_q, pay_d;
  logic [7:0]    data_q, data_d;
  logic          sof_q, sof_d;
  logic [3:0]    pos_q, pos_d;
  logic [15:0]   fs_q, fs_d;

  logic          fifo_pop, fifo_full, fifo_empty, enough;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;

  frame_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (s_valid & ~fifo_full),
    .wdata_i (s_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Only start a frame with a whole payload buffered, so DATA never underruns.
  assign enough = (fifo_count >= CW'(PAYLOAD_LEN));

  // The state names what tx_data will carry; outputs are computed for state_d
  // and registered alongside it.
  always_comb begin
    state_d  = state_q;
    hsel_d   = hsel_q;
    corr_d   = corr_q;
    pay_d    = pay_q;
    fs_d     = fs_q;
    data_d   = IDLE_BYTE;
    sof_d    = 1'b0;
    pos_d    = 4'd0;
    fifo_pop = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (enable && enough) begin
          state_d = TX_HLSB;
          hsel_d  = hdr_sel;
          corr_d  = corrupt_hdr;
        end
      end
      TX_HLSB: state_d = TX_HMSB;
      TX_HMSB: begin
        state_d = TX_DATA;
        pay_d   = 4'd0;
      end
      TX_DATA: begin
        if (pay_q == 4'(PAYLOAD_LEN-1)) begin
          fs_d = fs_q + 16'd1;
          // Back-to-back frame: no idle byte, headers re-latched.
          if (enable && enough) begin
            state_d = TX_HLSB;
            hsel_d  = hdr_sel;
            corr_d  = corrupt_hdr;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          pay_d = pay_q + 4'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    case (state_d)
      TX_HLSB: begin
        data_d = hdr_byte(hsel_d, 1'b0);
        sof_d  = 1'b1;
      end
      TX_HMSB: begin
        data_d = hdr_byte(hsel_d, 1'b1) ^ {8{corr_d}};
        pos_d  = 4'd1;
      end
      TX_DATA: begin
        fifo_pop = ~fifo_empty;
        data_d   = fifo_rdata;
        pos_d    = 4'd2 + pay_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
      hsel_q  <= 1'b0;
      corr_q  <= 1'b0;
      pay_q   <= 4'd0;
      data_q  <= IDLE_BYTE;
      sof_q   <= 1'b0;
      pos_q   <= 4'd0;
      fs_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      hsel_q  <= hsel_d;
      corr_q  <= corr_d;
      pay_q   <= pay_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      pos_q   <= pos_d;
      fs_q    <= fs_d;
    end
  end

  assign s_ready     = ~fifo_full;
  assign tx_data     = data_q;
  assign tx_sof      = sof_q;
  assign tx_byte_pos = pos_q;
  assign frames_sent = fs_q;

endmodule

// File: tb/tb_frame_generator.sv
module tb_frame_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        hdr_sel = 1'b0;
  logic        corrupt_hdr = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  tx_data;
  logic        tx_sof;
  logic [3:0]  tx_byte_pos;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;
  int acc;
  logic [15:0] fs_exp = 16'd0;

  logic [7:0] push_q[$];
  logic [7:0] cap_data [64];
  logic       cap_sof  [64];
  logic [3:0] cap_pos  [64];

  frame_generator dut (
    .clk(clk), .reset(reset), .enable(enable), .hdr_sel(hdr_sel),
    .corrupt_hdr(corrupt_hdr), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .tx_data(tx_data), .tx_sof(tx_sof),
    .tx_byte_pos(tx_byte_pos), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive n cycles, offering bytes from push_q, capturing the output stream.
  task automatic run(input int n);
    acc = 0;
    for (int c = 0; c < n; c++) begin
      logic take;
      s_valid = (push_q.size() > 0);
      s_data  = s_valid ? push_q[0] : 8'h00;
      take    = s_valid && s_ready;
      tick();
      if (take) begin
        void'(push_q.pop_front());
        acc++;
      end
      cap_data[c] = tx_data;
      cap_sof[c]  = tx_sof;
      cap_pos[c]  = tx_byte_pos;
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (tx_data !== 8'h00 || tx_sof !== 1'b0 || tx_byte_pos !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h sof=%b pos=%0d, want 00/0/0", tx_data, tx_sof, tx_byte_pos);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (s_ready !== 1'b1 || frames_sent !== 16'd0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: s_ready=%b frames=%0d data=%h, want 1/0/00", s_ready, frames_sent, tx_data);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] exp [12];
    for (int i = 0; i < 10; i++) push_q.push_back(8'(i + 1));
    enable = 1'b0;
    run(10);
    checks++;
    if (acc !== 10 || cap_data[9] !== 8'h00) begin
      errors++;
      $display("FAIL single_fill: accepted=%0d data=%h, want 10/00", acc, cap_data[9]);
    end
    enable = 1'b1; hdr_sel = 1'b0; corrupt_hdr = 1'b0;
    tick();
    checks++;
    if (tx_data !== 8'hAA || tx_sof !== 1'b1 || tx_byte_pos !== 4'd0) begin
      errors++;
      $display("FAIL single_hlsb: data=%h sof=%b pos=%0d, want AA/1/0", tx_data, tx_sof, tx_byte_pos);
    end
    // Mid-frame changes must not touch the frame in flight.
    enable = 1'b0; hdr_sel = 1'b1; corrupt_hdr = 1'b1;
    run(12);
    exp[0] = 8'hAF;
    for (int i = 1; i <= 10; i++) exp[i] = 8'(i);
    exp[11] = 8'h00;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (cap_data[i] !== exp[i] || cap_sof[i] !== 1'b0 ||
          cap_pos[i] !== ((i < 11) ? 4'(i + 1) : 4'd0)) begin
        errors++;
        $display("FAIL single_byte%0d: data=%h sof=%b pos=%0d, want %h/0/%0d",
                 i, cap_data[i], cap_sof[i], cap_pos[i], exp[i], (i < 11) ? i + 1 : 0);
      end
    end
    fs_exp = 16'd1;
    checks++;
    if (frames_sent !== fs_exp) begin
      errors++;
      $display("FAIL single_frames: got %0d want %0d", frames_sent, fs_exp);
    end
    hdr_sel = 1'b0; corrupt_hdr = 1'b0;
  endtask

  // Stream 30 bytes with enable high; expect 3 frames with no idle gap.
  task automatic stream3(input string nm, input logic sel, input logic corr, input logic [7:0] base);
    logic [7:0] pay [30];
    logic [7:0] lsb, msb;
    int k;
    lsb = sel ? 8'h55 : 8'hAA;
    msb = sel ? 8'hBA : (corr ? 8'h50 : 8'hAF);
    for (int i = 0; i < 30; i++) begin
      pay[i] = (i == 14) ? 8'hAA : (i == 21 ? 8'h55 : base + 8'(i));
      push_q.push_back(pay[i]);
    end
    enable = 1'b1; hdr_sel = sel; corrupt_hdr = corr;
    run(52);
    enable = 1'b0;
    checks++;
    if (cap_data[9] !== 8'h00 || cap_data[10] !== lsb || cap_sof[10] !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: idx9=%h idx10=%h sof=%b, want 00/%h/1", nm, cap_data[9], cap_data[10], cap_sof[10], lsb);
    end
    for (int f = 0; f < 3; f++) begin
      k = 10 + f * 12;
      checks++;
      if (cap_data[k] !== lsb || cap_data[k+1] !== msb || cap_sof[k] !== 1'b1 || cap_pos[k+1] !== 4'd1) begin
        errors++;
        $display("FAIL %s_hdr%0d: %h %h sof=%b, want %h %h sof=1", nm, f, cap_data[k], cap_data[k+1], cap_sof[k], lsb, msb);
      end
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (cap_data[k+2+j] !== pay[f*10+j] || cap_pos[k+2+j] !== 4'(j + 2)) begin
          errors++;
          $display("FAIL %s_f%0d_b%0d: data=%h pos=%0d, want %h/%0d", nm, f, j, cap_data[k+2+j], cap_pos[k+2+j], pay[f*10+j], j + 2);
        end
      end
    end
    checks++;
    if (cap_data[46] !== 8'h00 || cap_pos[46] !== 4'd0) begin
      errors++;
      $display("FAIL %s_tail: data=%h pos=%0d, want 00/0", nm, cap_data[46], cap_pos[46]);
    end
    fs_exp = fs_exp + 16'd3;
    checks++;
    if (frames_sent !== fs_exp) begin
      errors++;
      $display("FAIL %s_frames: got %0d want %0d", nm, frames_sent, fs_exp);
    end
    hdr_sel = 1'b0; corrupt_hdr = 1'b0;
  endtask

  task automatic test_back_to_back();
    stream3("b2b", 1'b1, 1'b0, 8'h10);
  endtask

  task automatic test_corrupt();
    stream3("corrupt", 1'b0, 1'b1, 8'h80);
  endtask

  task automatic test_backpressure();
    bit bad;
    enable = 1'b0;
    for (int i = 0; i < 17; i++) push_q.push_back(8'h40 + 8'(i));
    run(20);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) if (cap_data[i] !== 8'h00) bad = 1'b1;
    checks++;
    if (acc !== 16 || s_ready !== 1'b0 || push_q.size() !== 1 || bad) begin
      errors++;
      $display("FAIL bp_full: accepted=%0d s_ready=%b held=%0d nonidle=%b, want 16/0/1/0", acc, s_ready, push_q.size(), bad);
    end
    enable = 1'b1; hdr_sel = 1'b0;
    run(20);
    checks++;
    if (cap_data[0] !== 8'hAA || cap_data[1] !== 8'hAF || cap_data[2] !== 8'h40 || cap_data[11] !== 8'h49) begin
      errors++;
      $display("FAIL bp_frame1: %h %h %h..%h, want AA AF 40..49", cap_data[0], cap_data[1], cap_data[2], cap_data[11]);
    end
    bad = 1'b0;
    for (int i = 12; i < 20; i++) if (cap_data[i] !== 8'h00) bad = 1'b1;
    checks++;
    if (acc !== 1 || s_ready !== 1'b1 || bad) begin
      errors++;
      $display("FAIL bp_after1: accepted=%0d s_ready=%b nonidle=%b, want 1/1/0", acc, s_ready, bad);
    end
    for (int i = 0; i < 3; i++) push_q.push_back(8'h51 + 8'(i));
    run(20);
    checks++;
    if (cap_data[2] !== 8'h00 || cap_data[3] !== 8'hAA || cap_data[4] !== 8'hAF) begin
      errors++;
      $display("FAIL bp_frame2_start: idx2=%h idx3=%h idx4=%h, want 00 AA AF", cap_data[2], cap_data[3], cap_data[4]);
    end
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (cap_data[5+j] !== 8'h4A + 8'(j)) begin
        errors++;
        $display("FAIL bp_frame2_b%0d: got %h want %h", j, cap_data[5+j], 8'h4A + 8'(j));
      end
    end
    enable = 1'b0;
    fs_exp = fs_exp + 16'd2;
    checks++;
    if (frames_sent !== fs_exp) begin
      errors++;
      $display("FAIL bp_frames: got %0d want %0d", frames_sent, fs_exp);
    end
  endtask

  task automatic test_reset_midframe();
    bit found, bad;
    for (int i = 0; i < 10; i++) push_q.push_back(8'h61 + 8'(i));
    enable = 1'b1; hdr_sel = 1'b0;
    run(10);
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      tick();
      if (tx_byte_pos == 4'd6) found = 1'b1;
    end
    checks++;
    if (!found || tx_data !== 8'h65) begin
      errors++;
      $display("FAIL cut_reach: found=%b data=%h, want 1/65", found, tx_data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx_data !== 8'h00 || tx_byte_pos !== 4'd0 || frames_sent !== 16'd0) begin
      errors++;
      $display("FAIL cut_async: data=%h pos=%0d frames=%0d, want 00/0/0", tx_data, tx_byte_pos, frames_sent);
    end
    tick();
    reset = 1'b0;
    tick();
    fs_exp = 16'd0;
    for (int i = 0; i < 9; i++) push_q.push_back(8'h71 + 8'(i));
    run(15);
    bad = 1'b0;
    for (int i = 0; i < 15; i++) if (cap_data[i] !== 8'h00) bad = 1'b1;
    checks++;
    if (bad || s_ready !== 1'b1 || frames_sent !== fs_exp) begin
      errors++;
      $display("FAIL cut_noframe: nonidle=%b s_ready=%b frames=%0d, want 0/1/0", bad, s_ready, frames_sent);
    end
    push_q.push_back(8'h7A);
    run(20);
    checks++;
    if (cap_data[0] !== 8'h00 || cap_data[1] !== 8'hAA || cap_data[2] !== 8'hAF) begin
      errors++;
      $display("FAIL cut_restart: %h %h %h, want 00 AA AF", cap_data[0], cap_data[1], cap_data[2]);
    end
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (cap_data[3+j] !== 8'h71 + 8'(j)) begin
        errors++;
        $display("FAIL cut_b%0d: got %h want %h", j, cap_data[3+j], 8'h71 + 8'(j));
      end
    end
    enable = 1'b0;
    fs_exp = 16'd1;
    checks++;
    if (frames_sent !== fs_exp) begin
      errors++;
      $display("FAIL cut_frames: got %0d want %0d", frames_sent, fs_exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_corrupt();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
